// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Write-side handshake bundle for the seven-segment scan scheduler.
//
// Signals:
//   wr_data   [31:0]  new frame, digit k = bits [4k+3:4k], digit 7 most significant
//   wr_blink  [7:0]   per-digit blink mask, bit k = digit k
//   wr_lz_en          leading-zero suppression enable
//   wr_valid          write request
//   wr_ready          shadow buffer free; write accepted on wr_valid && wr_ready
//
// Modports:
//   master  - producer of frames (drives data/valid, observes ready)
//   slave   - the scan controller (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if;
    logic [31:0] wr_data;
    logic [7:0]  wr_blink;
    logic        wr_lz_en;
    logic        wr_valid;
    logic        wr_ready;

    modport master (
        output wr_data,
        output wr_blink,
        output wr_lz_en,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_blink,
        input  wr_lz_en,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Scan scheduler for an 8-digit multiplexed seven-segment display.
// A 32-bit frame (8 nibbles) is double-buffered: writes land in a shadow
// buffer and are copied to the active buffer only at a frame boundary, so the
// display never shows a mix of two frames. Each digit owns a slot of SCAN_DIV
// cycles; the first BLANK_CYC cycles of the slot keep every digit off to
// avoid ghosting. Leading-zero suppression and per-digit blink can force a
// digit dark during its show phase.
//
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (must exceed BLANK_CYC)
//   BLANK_CYC     blanking cycles at the start of each slot (>= 1)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   wr          write handshake (slave modport of seg_scan_ctrl_if)
//   digit_idx   digit currently in its slot
//   nibble      active value of digit_idx, to the segment decoder
//   blank       1 = decoder output must be forced off
//   sig         digit selects, active-low one-hot, 8'hFF = all off
//   frame_tick  one-cycle pulse on the last cycle of the digit 7 slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_ctrl_if.slave    wr,
    output logic [2:0]        digit_idx,
    output logic [3:0]        nibble,
    output logic              blank,
    output logic [7:0]        sig,
    output logic              frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST     = BLK_W'(BLINK_FRAMES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;

    logic [31:0] act_data;
    logic [7:0]  act_blink;
    logic        act_lz;
    logic [31:0] sh_data;
    logic [7:0]  sh_blink;
    logic        sh_lz;
    logic        pending;

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_ph;

    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       idx_n;
    logic [0:0]       state_n;
    logic             slot_end;
    logic             accept;
    logic             apply;
    logic [31:0]      act_data_n;
    logic [7:0]       act_blink_n;
    logic             act_lz_n;
    logic [BLK_W-1:0] blink_cnt_n;
    logic             blink_ph_n;
    logic [7:0]       zero_from;
    logic             zacc;
    logic             lz_sup;
    logic             bl_sup;
    logic             off_n;
    logic [7:0]       sig_n;
    logic [3:0]       nibble_n;
    logic             tick_n;

    assign wr.wr_ready = ~pending;
    assign accept      = wr.wr_valid & ~pending;
    // frame_tick is registered, so it marks the current cycle as the last of
    // the frame; a frame already waiting in the shadow goes live on this edge.
    assign apply       = frame_tick & pending;

    // Slot sequencing: the next counter/digit/phase values. The output
    // registers are loaded from these so they always describe the cycle
    // that is about to begin, keeping every output purely registered.
    always_comb begin
        slot_end = (cnt == CNT_LAST);
        cnt_n    = slot_end ? '0 : cnt + CNT_W'(1);
        idx_n    = slot_end ? digit_idx + 3'd1 : digit_idx;
        state_n  = state;
        case (state)
            ST_BLANK: if (cnt == CNT_BLANK_LAST) state_n = ST_SHOW;
            ST_SHOW:  if (slot_end)              state_n = ST_BLANK;
            default:                             state_n = ST_BLANK;
        endcase
    end

    // Active buffer and blink state as they will be in the next cycle, so a
    // new frame and a blink toggle take effect on the very first cycle of
    // the new frame.
    always_comb begin
        act_data_n  = apply ? sh_data  : act_data;
        act_blink_n = apply ? sh_blink : act_blink;
        act_lz_n    = apply ? sh_lz    : act_lz;
        blink_cnt_n = blink_cnt;
        blink_ph_n  = blink_ph;
        if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_ph_n  = ~blink_ph;
            end else begin
                blink_cnt_n = blink_cnt + BLK_W'(1);
            end
        end
    end

    // zero_from[k] is set when digit k and every digit above it are zero,
    // which is exactly the leading-zero condition for digit k.
    always_comb begin
        zero_from = '0;
        zacc      = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            zacc         = zacc & (act_data_n[4*k +: 4] == 4'd0);
            zero_from[k] = zacc;
        end
    end

    always_comb begin
        lz_sup   = act_lz_n & (idx_n != 3'd0) & zero_from[idx_n];
        bl_sup   = blink_ph_n & act_blink_n[idx_n];
        off_n    = (state_n == ST_BLANK) | lz_sup | bl_sup;
        sig_n    = off_n ? 8'hFF : ~(8'd1 << idx_n);
        nibble_n = act_data_n[{idx_n, 2'b00} +: 4];
        tick_n   = (cnt_n == CNT_LAST) & (idx_n == 3'd7);
    end

    // Slot counter, FSM and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            state      <= ST_BLANK;
            digit_idx  <= 3'd0;
            sig        <= 8'hFF;
            blank      <= 1'b1;
            nibble     <= 4'd0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            state      <= state_n;
            digit_idx  <= idx_n;
            sig        <= sig_n;
            blank      <= off_n;
            nibble     <= nibble_n;
            frame_tick <= tick_n;
        end
    end

    // Double buffer: a handshake can only happen while nothing is pending,
    // and the shadow is copied to active only while something is pending,
    // so the two never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_data   <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
            act_data  <= '0;
            act_blink <= '0;
            act_lz    <= 1'b0;
            pending   <= 1'b0;
        end else begin
            act_data  <= act_data_n;
            act_blink <= act_blink_n;
            act_lz    <= act_lz_n;
            if (accept) begin
                sh_data  <= wr.wr_data;
                sh_blink <= wr.wr_blink;
                sh_lz    <= wr.wr_lz_en;
                pending  <= 1'b1;
            end else if (apply) begin
                pending  <= 1'b0;
            end
        end
    end

    // Blink half-period counter, advanced once per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_n;
            blink_ph  <= blink_ph_n;
        end
    end

endmodule
